// File: rtl/shared_reg_arb_pkg.sv
// rtl/shared_reg_arb_pkg.sv - shared types, defaults and helpers for the shared register arbiter
package shared_reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int NUM_REQ_DEF  = 4;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_HOLD_DEF = 8;
  localparam int MAX_REQ      = 8;

  // Sized for the largest supported requester count; callers cast down to NUM_REQ.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_picker.sv
// rtl/shared_reg_arbiter_rr_picker.sv - round-robin pick of the next requester after last_id
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic               any,
  output logic [ID_W-1:0]    pick_id
);

  localparam int W = ID_W + 1;

  logic [NUM_REQ-1:0] rot;
  logic [W-1:0]       start;
  logic [W-1:0]       off;
  logic [W-1:0]       sum;

  always_comb begin
    any   = |req;
    start = {1'b0, last_id} + W'(1);
    // Doubling the vector lets a plain shift act as a rotate, including start==NUM_REQ.
    rot   = NUM_REQ'({req, req} >> start);
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
    sum = start + off;
    if (sum >= W'(NUM_REQ)) sum = sum - W'(NUM_REQ);
    pick_id = sum[ID_W-1:0];
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin owner arbitration for one shared holding register
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter  int NUM_REQ  = NUM_REQ_DEF,
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int MAX_HOLD = MAX_HOLD_DEF,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        rel,
  input  logic [NUM_REQ-1:0]        wr_en,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      gnt_valid,
  output logic [ID_W-1:0]           gnt_id,
  output logic [DATA_W-1:0]         shared_q,
  output logic                      timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_e              state_q;
  state_e              state_d;
  logic [HOLD_W-1:0]   hold_q;
  logic [ID_W-1:0]     last_id_q;
  logic [ID_W-1:0]     pick_id;
  logic                any_req;
  logic                own_req;
  logic                own_rel;
  logic                own_wr_en;
  logic [DATA_W-1:0]   own_data;
  logic                hold_max;
  logic                own_exit;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req     (req),
    .last_id (last_id_q),
    .any     (any_req),
    .pick_id (pick_id)
  );

  // Owner mux: only the granted requester's controls and data are visible downstream.
  always_comb begin
    own_req   = 1'b0;
    own_rel   = 1'b0;
    own_wr_en = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      case (gnt_id)
        ID_W'(i): begin
          own_req   = req[i];
          own_rel   = rel[i];
          own_wr_en = wr_en[i];
          own_data  = wr_data[i*DATA_W +: DATA_W];
        end
        default: ;
      endcase
    end
  end

  assign hold_max = (hold_q == HOLD_W'(MAX_HOLD));
  assign own_exit = own_rel || !own_req || hold_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      gnt_id    <= '0;
      last_id_q <= ID_W'(NUM_REQ - 1);
      shared_q  <= '0;
      timeout   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Release or a dropped request takes precedence over the hold limit.
      timeout <= (state_q == OWN) && hold_max && !own_rel && own_req;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_id    <= pick_id;
            last_id_q <= pick_id;
            hold_q    <= HOLD_W'(1);
          end
        end
        OWN: begin
          if (own_wr_en) shared_q <= own_data;
          if (!own_exit && !hold_max) hold_q <= hold_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = OWN;
      OWN:     if (own_exit) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_valid = (state_q == OWN);
    gnt       = gnt_valid ? NUM_REQ'(onehot(3'(gnt_id))) : '0;
  end

endmodule
